// File: rtl/cond_exec_if.sv
// Decode-to-execute control bundle for cond_exec_stage: decoder fields in,
// condition-gated strobes and architectural flags out.
interface cond_exec_if;
  logic       valid_d;
  logic [3:0] cond_d;
  logic       regw_d;
  logic       memw_d;
  logic       memtoreg_d;
  logic       alusrc_d;
  logic       branch_d;
  logic       aluop_d;
  logic       pcs_d;
  logic [1:0] flagw_d;
  logic [3:0] alu_flags_e;
  logic       stall_e;
  logic       flush_e;

  logic       regwrite_e;
  logic       memwrite_e;
  logic       pcsrc_e;
  logic       branch_taken_e;
  logic       memtoreg_e;
  logic       alusrc_e;
  logic       aluop_e;
  logic       condex_e;
  logic [3:0] flags;

  modport master (
    output valid_d, cond_d, regw_d, memw_d, memtoreg_d, alusrc_d, branch_d,
           aluop_d, pcs_d, flagw_d, alu_flags_e, stall_e, flush_e,
    input  regwrite_e, memwrite_e, pcsrc_e, branch_taken_e, memtoreg_e,
           alusrc_e, aluop_e, condex_e, flags
  );

  modport slave (
    input  valid_d, cond_d, regw_d, memw_d, memtoreg_d, alusrc_d, branch_d,
           aluop_d, pcs_d, flagw_d, alu_flags_e, stall_e, flush_e,
    output regwrite_e, memwrite_e, pcsrc_e, branch_taken_e, memtoreg_e,
           alusrc_e, aluop_e, condex_e, flags
  );
endinterface

// File: rtl/cond_exec_stage.sv
// ID/EX control register with NZCV flag register and condition-gated
// register-write, memory-write, PC-select and branch strobes.
module cond_exec_stage (
  input  logic        clk,
  input  logic        reset,
  cond_exec_if.slave  bus
);

  logic       valid_p1;
  logic [3:0] cond_p1;
  logic       regw_p1;
  logic       memw_p1;
  logic       memtoreg_p1;
  logic       alusrc_p1;
  logic       branch_p1;
  logic       aluop_p1;
  logic       pcs_p1;
  logic [1:0] flagw_p1;
  logic [3:0] flags_q;
  logic       condex;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c & !z;
      4'b1001: cond_pass = !c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Decode -> EX boundary: flush outranks stall so a held slot can still be squashed.
  always_ff @(posedge clk) begin
    if (reset || bus.flush_e) begin
      valid_p1    <= 1'b0;
      cond_p1     <= 4'b0000;
      regw_p1     <= 1'b0;
      memw_p1     <= 1'b0;
      memtoreg_p1 <= 1'b0;
      alusrc_p1   <= 1'b0;
      branch_p1   <= 1'b0;
      aluop_p1    <= 1'b0;
      pcs_p1      <= 1'b0;
      flagw_p1    <= 2'b00;
    end else if (!bus.stall_e) begin
      valid_p1    <= bus.valid_d;
      cond_p1     <= bus.cond_d;
      regw_p1     <= bus.regw_d;
      memw_p1     <= bus.memw_d;
      memtoreg_p1 <= bus.memtoreg_d;
      alusrc_p1   <= bus.alusrc_d;
      branch_p1   <= bus.branch_d;
      aluop_p1    <= bus.aluop_d;
      pcs_p1      <= bus.pcs_d;
      flagw_p1    <= bus.flagw_d;
    end
  end

  assign condex = valid_p1 & cond_pass(cond_p1, flags_q);

  // EX -> flag register: a stalled instruction commits its flags only on the edge it leaves EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (condex && !bus.stall_e) begin
      if (flagw_p1[1]) flags_q[3:2] <= bus.alu_flags_e[3:2];
      if (flagw_p1[0]) flags_q[1:0] <= bus.alu_flags_e[1:0];
    end
  end

  assign bus.condex_e       = condex;
  assign bus.regwrite_e     = regw_p1 & condex;
  assign bus.memwrite_e     = memw_p1 & condex;
  assign bus.pcsrc_e        = pcs_p1 & condex;
  assign bus.branch_taken_e = branch_p1 & condex;
  assign bus.memtoreg_e     = memtoreg_p1;
  assign bus.alusrc_e       = alusrc_p1;
  assign bus.aluop_e        = aluop_p1;
  assign bus.flags          = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Randomized and directed bench for cond_exec_stage against an
// instruction-level reference model of the EX slot and NZCV flags.
module tb_cond_exec_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  cond_exec_if bus ();

  cond_exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: contents of the EX slot as an instruction record, plus flags.
  typedef struct {
    logic       valid;
    logic [3:0] cond;
    logic       regw, memw, memtoreg, alusrc, branch, aluop, pcs;
    logic [1:0] flagw;
  } instr_t;

  instr_t     m_ex;
  logic [3:0] m_flags;
  logic       m_live;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Conditions come in complementary pairs: even code = base test, odd code = its inverse.
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    if (code == 4'd15) return 1'b0;
    if (code == 4'd14) return 1'b1;
    case (code / 2)
      0: base = fz;
      1: base = fc;
      2: base = fn;
      3: base = fv;
      4: base = fc && !fz;
      5: base = (fn == fv);
      default: base = !fz && (fn == fv);
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  task automatic check_outputs();
    logic ok;
    ok = m_ex.valid && ref_cond(m_ex.cond, m_flags);
    chk("condex", {3'b0, bus.condex_e}, {3'b0, ok});
    chk("regwrite", {3'b0, bus.regwrite_e}, {3'b0, ok && m_ex.regw});
    chk("memwrite", {3'b0, bus.memwrite_e}, {3'b0, ok && m_ex.memw});
    chk("pcsrc", {3'b0, bus.pcsrc_e}, {3'b0, ok && m_ex.pcs});
    chk("branch_taken", {3'b0, bus.branch_taken_e}, {3'b0, ok && m_ex.branch});
    chk("flags", bus.flags, m_flags);
    if (m_live) begin
      chk("memtoreg", {3'b0, bus.memtoreg_e}, {3'b0, m_ex.memtoreg});
      chk("alusrc", {3'b0, bus.alusrc_e}, {3'b0, m_ex.alusrc});
      chk("aluop", {3'b0, bus.aluop_e}, {3'b0, m_ex.aluop});
    end
  endtask

  // Advance one clock: model the edge from the current inputs, then compare.
  task automatic tick();
    instr_t     nx;
    logic [3:0] nf;
    logic       nlive;
    logic       ok;
    ok = m_ex.valid && ref_cond(m_ex.cond, m_flags);
    nf = m_flags;
    if (reset) nf = 4'b0000;
    else if (ok && !bus.stall_e) begin
      if (m_ex.flagw[1]) nf[3:2] = bus.alu_flags_e[3:2];
      if (m_ex.flagw[0]) nf[1:0] = bus.alu_flags_e[1:0];
    end
    nx = m_ex;
    nlive = m_live;
    if (reset || bus.flush_e) begin
      nx = '{valid: 1'b0, cond: 4'b0, regw: 1'b0, memw: 1'b0, memtoreg: 1'b0,
             alusrc: 1'b0, branch: 1'b0, aluop: 1'b0, pcs: 1'b0, flagw: 2'b0};
      nlive = reset;
    end else if (!bus.stall_e) begin
      nx = '{valid: bus.valid_d, cond: bus.cond_d, regw: bus.regw_d, memw: bus.memw_d,
             memtoreg: bus.memtoreg_d, alusrc: bus.alusrc_d, branch: bus.branch_d,
             aluop: bus.aluop_d, pcs: bus.pcs_d, flagw: bus.flagw_d};
      nlive = 1'b1;
    end
    @(posedge clk);
    #1;
    m_ex = nx;
    m_flags = nf;
    m_live = nlive;
    check_outputs();
  endtask

  task automatic dec(input logic v, input logic [3:0] c, input logic rw, input logic mw,
                     input logic br, input logic pcs, input logic [1:0] fw);
    bus.valid_d = v;   bus.cond_d = c;    bus.regw_d = rw;  bus.memw_d = mw;
    bus.branch_d = br; bus.pcs_d = pcs;   bus.flagw_d = fw;
    bus.memtoreg_d = 1'b0; bus.alusrc_d = 1'b0; bus.aluop_d = 1'b0;
  endtask

  initial begin
    m_ex = '{valid: 1'b0, cond: 4'b0, regw: 1'b0, memw: 1'b0, memtoreg: 1'b0,
             alusrc: 1'b0, branch: 1'b0, aluop: 1'b0, pcs: 1'b0, flagw: 2'b0};
    m_flags = 4'b0; m_live = 1'b1;
    reset = 1'b1;
    dec(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
    bus.alu_flags_e = 4'hF; bus.stall_e = 1'b0; bus.flush_e = 1'b0;
    tick(); tick();
    chk("rst_flags", bus.flags, 4'b0000);
    chk("rst_condex", {3'b0, bus.condex_e}, 4'b0);

    // Unconditional register write
    reset = 1'b0;
    dec(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("al_regwrite", {3'b0, bus.regwrite_e}, 4'b1);
    chk("al_condex", {3'b0, bus.condex_e}, 4'b1);
    chk("al_flags", bus.flags, 4'b0000);

    // Compare sets Z, then EQ passes and NE fails
    dec(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b0100;
    dec(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk("cmp_flags", bus.flags, 4'b0100);
    chk("eq_memwrite", {3'b0, bus.memwrite_e}, 4'b1);
    dec(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    chk("ne_memwrite", {3'b0, bus.memwrite_e}, 4'b0);

    // Partial update: only C,V replaced
    dec(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b1001;
    dec(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    tick();
    chk("set1001", bus.flags, 4'b1001);
    bus.alu_flags_e = 4'b0110;
    dec(1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    chk("partial_cv", bus.flags, 4'b1010);

    // GE branch with N=1,V=0 fails, with N=1,V=1 passes
    dec(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b1000;
    dec(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    chk("ge_fail_br", {3'b0, bus.branch_taken_e}, 4'b0);
    chk("ge_fail_pc", {3'b0, bus.pcsrc_e}, 4'b0);
    dec(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b1001;
    dec(1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    chk("ge_pass_br", {3'b0, bus.branch_taken_e}, 4'b1);
    chk("ge_pass_pc", {3'b0, bus.pcsrc_e}, 4'b1);

    // Stall a flag setter for three cycles; flags move only on release
    dec(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b0101;
    bus.stall_e = 1'b1;
    dec(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_regwrite", {3'b0, bus.regwrite_e}, 4'b1);
      chk("stall_flags", bus.flags, 4'b1001);
    end
    bus.stall_e = 1'b0;
    tick();
    chk("release_flags", bus.flags, 4'b0101);

    // Flush with stall: bubble, and the flag setter in EX must not write
    dec(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b1111;
    bus.flush_e = 1'b1; bus.stall_e = 1'b1;
    dec(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    chk("flush_condex", {3'b0, bus.condex_e}, 4'b0);
    chk("flush_regwrite", {3'b0, bus.regwrite_e}, 4'b0);
    chk("flush_flags", bus.flags, 4'b0101);
    bus.flush_e = 1'b0; bus.stall_e = 1'b0;

    // Reset mid-stream
    dec(1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
    tick();
    bus.alu_flags_e = 4'b0110;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_flags", bus.flags, 4'b0000);
    chk("midrst_regwrite", {3'b0, bus.regwrite_e}, 4'b0);
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      bus.valid_d     = ($urandom_range(0, 9) != 0);
      bus.cond_d      = 4'($urandom_range(0, 15));
      bus.regw_d      = 1'($urandom_range(0, 1));
      bus.memw_d      = 1'($urandom_range(0, 1));
      bus.memtoreg_d  = 1'($urandom_range(0, 1));
      bus.alusrc_d    = 1'($urandom_range(0, 1));
      bus.branch_d    = 1'($urandom_range(0, 1));
      bus.aluop_d     = 1'($urandom_range(0, 1));
      bus.pcs_d       = 1'($urandom_range(0, 1));
      bus.flagw_d     = 2'($urandom_range(0, 3));
      bus.alu_flags_e = 4'($urandom_range(0, 15));
      bus.stall_e     = ($urandom_range(0, 4) == 0);
      bus.flush_e     = ($urandom_range(0, 9) == 0);
      reset           = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-stage control block for the pipelined core, directly downstream of the main decoder. It registers the decoder's control bits and the instruction condition field into an ID/EX control register, and holds the architectural NZCV flag register. It evaluates the condition against the flags and produces the condition-gated register-write, memory-write and PC-select strobes used by the execute, memory and fetch stages. It implements stall and flush for the hazard unit.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- valid_d  in  1  decode slot holds a real instruction
- cond_d  in  4  instruction condition field
- regw_d, memw_d, memtoreg_d, alusrc_d, branch_d, aluop_d  in  1 each  main-decoder outputs
- pcs_d  in  1  instruction writes PC (branch, or regW with Rd = PC)
- flagw_d  in  2  [1] = update N,Z; [0] = update C,V
- alu_flags_e  in  4  NZCV result of the ALU for the instruction now in EX
- stall_e  in  1  hold EX contents
- flush_e  in  1  replace EX contents with a bubble
- regwrite_e, memwrite_e, pcsrc_e, branch_taken_e  out  1 each  gated strobes
- memtoreg_e, alusrc_e, aluop_e  out  1 each  registered, ungated
- condex_e  out  1  condition passed and valid
- flags  out  4  architectural NZCV

## Operation
- ID/EX register load priority at each edge: reset > flush_e > stall_e > load.
  - reset: all EX fields 0 (valid_e = 0, cond_e = 0000), flags = 0000.
  - flush_e: bubble. valid_e = 0 and all write enables are 0. flush_e wins over stall_e.
  - stall_e: every EX field holds.
  - otherwise: every *_d input is captured.
- Condition decode of cond_e against the stored flags (not alu_flags_e):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 → 0
- condex_e = valid_e & cond_pass.
- Gated outputs:
  - regwrite_e = regw_e & condex_e
  - memwrite_e = memw_e & condex_e
  - pcsrc_e = pcs_e & condex_e
  - branch_taken_e = branch_e & condex_e
- Flag register:
  - N,Z ← alu_flags_e[3:2] when flagw_e[1] & condex_e & !stall_e.
  - C,V ← alu_flags_e[1:0] when flagw_e[0] & condex_e & !stall_e.
  - Otherwise the flags hold.
  - A stalled instruction updates flags once, on the cycle it leaves EX.
- A flushed or failed-condition instruction never changes flags or asserts any gated strobe.

## Timing
- Decode-to-EX latency is 1 cycle. Gated outputs are combinational from EX registers plus the flag register.
- No combinational path from alu_flags_e to any output except through the flag register.
- Flags written at edge N are seen by the instruction in EX during cycle N+1, so back-to-back set-then-test needs no forwarding.
- Reset asserted mid-stream: on the next edge EX becomes a bubble and flags clear. All gated outputs are 0 from that cycle until a valid instruction is loaded after reset deasserts.
- Reset values: every output 0, flags 0000.
- Simultaneous flush_e and stall_e: flush takes effect; the instruction in EX is not allowed to write flags (stall suppresses it).

## Test plan
- Reset, then load valid_d=1, cond_d=1110, regw_d=1 → one cycle later regwrite_e=1, condex_e=1; flags remain 0000.
- Flag-setting compare: flagw_d=11, alu_flags_e=0100 in EX → flags=0100 next cycle. Follow-on cond_d=0000 (EQ) with memw_d=1 → memwrite_e=1. Follow-on cond_d=0001 (NE) → memwrite_e=0.
- Partial update: flags=1001, EX flagw_e=01, alu_flags_e=0110 → flags=1010 (N,Z kept; C,V replaced).
- Branch with cond_d=1010 (GE), flags N=1,V=0 → branch_taken_e=0, pcsrc_e=0. Same with V=1 → both 1.
- stall_e held 3 cycles with a flag-setting instruction in EX, then released → EX outputs constant for 3 cycles; flags change only on the release edge.
- flush_e and stall_e asserted together with a regw instruction in decode → next cycle valid_e=0 and every gated strobe is 0. Also verify reset pulsed mid-sequence clears flags to 0000 and EX to a bubble.
